// File: rtl/edge_event_pkg.sv
// Shared definitions for the edge event recorder: event word layout, drop counter
// width and the capture state encoding.
package edge_event_pkg;

  // Drop counter width; the counter saturates at its all-ones value.
  localparam int unsigned DROP_W = 8;

  // Event word is {a_now, b_now, a_chg, b_chg, timestamp}. The timestamp starts at
  // TS_LSB; the flag offsets are relative to the bit just above the timestamp, so the
  // absolute position of a flag is TS_W + <offset>.
  localparam int unsigned TS_LSB = 0;
  localparam int unsigned B_CHG  = 0;
  localparam int unsigned A_CHG  = 1;
  localparam int unsigned B_NOW  = 2;
  localparam int unsigned A_NOW  = 3;
  localparam int unsigned FLAG_W = 4;

  // PRIME only seeds the sample registers; RUN allows event detection.
  typedef enum logic [0:0] {
    StPrime = 1'b0,
    StRun   = 1'b1
  } rec_state_e;

  // Assemble the flag nibble that sits above the timestamp in an event word.
  function automatic logic [FLAG_W-1:0] pack_flags(input logic a_now,
                                                   input logic b_now,
                                                   input logic a_chg,
                                                   input logic b_chg);
    logic [FLAG_W-1:0] flags;
    flags        = '0;
    flags[A_NOW] = a_now;
    flags[B_NOW] = b_now;
    flags[A_CHG] = a_chg;
    flags[B_CHG] = b_chg;
    return flags;
  endfunction

endpackage

// File: rtl/edge_event_recorder_if.sv
// Read-side handshake of the edge event recorder. The recorder drives the master
// modport; the consumer of recorded events uses the slave modport.
interface edge_event_recorder_if #(
  parameter int unsigned TS_W = 12
);

  localparam int unsigned WORD_W = TS_W + edge_event_pkg::FLAG_W;

  logic              rd_valid;
  logic              rd_ready;
  logic [WORD_W-1:0] rd_data;

  modport master (
    output rd_valid,
    output rd_data,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_data,
    output rd_ready
  );

endinterface

// File: rtl/event_fifo.sv
// Synchronous first-in first-out buffer with occupancy count. Pointers wrap modulo
// DEPTH, which must be a power of two.
module event_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_LEVEL = DEPTH[CW-1:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // A pop needs data; a push needs a free slot or a slot freed by this cycle's pop.
  always_comb begin
    full    = (count_q == FULL_LEVEL);
    empty   = (count_q == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rdata   = mem_q[rptr_q];
    level   = count_q;
  end

  // Pointer and occupancy update; reset discards everything, including a same-cycle pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write; contents need no reset since they are only seen while not empty.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/edge_event_recorder.sv
// Edge event recorder: watches two synchronous signals, timestamps every cycle in
// which either changes, and queues the events for a valid/ready consumer. Events
// that find the queue full are dropped and counted.
module edge_event_recorder
  import edge_event_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TS_W  = 12
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        a_in,
  input  logic                        b_in,
  input  logic                        clr_ovf,
  edge_event_recorder_if.master       rd,
  output logic                        overflow,
  output logic [DROP_W-1:0]           drop_count,
  output logic [$clog2(DEPTH):0]      level
);

  localparam int unsigned WORD_W = TS_W + FLAG_W;

  rec_state_e        state_q;
  logic              a_q;
  logic              b_q;
  logic [TS_W-1:0]   ts_q;

  logic              detect;
  logic [WORD_W-1:0] evt_word_d;
  logic              evt_valid_q;
  logic [WORD_W-1:0] evt_word_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_rdata;
  logic              pop_now;
  logic              drop;

  logic              overflow_q;
  logic [DROP_W-1:0] drop_q;

  // Capture state: one PRIME cycle after reset release, then RUN until the next reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StPrime;
    end else begin
      unique case (state_q)
        StPrime: state_q <= StRun;
        StRun:   state_q <= StRun;
        default: state_q <= StPrime;
      endcase
    end
  end

  // Previous-cycle samples of the observed signals; these track even when disabled.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_q <= 1'b0;
      b_q <= 1'b0;
    end else begin
      a_q <= a_in;
      b_q <= b_in;
    end
  end

  // Free-running timestamp, independent of enable, wrapping at 2^TS_W.
  always_ff @(posedge clock) begin
    if (reset) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
    end
  end

  // Change detection; a simultaneous a/b change folds into a single event word.
  always_comb begin
    detect     = (state_q == StRun) && enable && ((a_in != a_q) || (b_in != b_q));
    evt_word_d = {pack_flags(a_in, b_in, a_in ^ a_q, b_in ^ b_q), ts_q};
  end

  // Event stage register: the detected word is offered to the queue one cycle later.
  always_ff @(posedge clock) begin
    if (reset) begin
      evt_valid_q <= 1'b0;
    end else begin
      evt_valid_q <= detect;
    end
    if (detect) begin
      evt_word_q <= evt_word_d;
    end
  end

  // A full queue still accepts the event when the consumer pops in the same cycle.
  always_comb begin
    pop_now = rd.rd_ready && !fifo_empty;
    drop    = evt_valid_q && fifo_full && !pop_now;
  end

  event_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_event_fifo (
    .clock (clock),
    .reset (reset),
    .push  (evt_valid_q),
    .wdata (evt_word_q),
    .pop   (rd.rd_ready),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Sticky overflow flag and saturating drop counter; a clear beats a coincident drop.
  always_ff @(posedge clock) begin
    if (reset || clr_ovf) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_q != '1) begin
        drop_q <= drop_q + DROP_W'(1);
      end
    end
  end

  // Read-side and status outputs.
  always_comb begin
    rd.rd_valid = !fifo_empty;
    rd.rd_data  = fifo_rdata;
    overflow    = overflow_q;
    drop_count  = drop_q;
  end

endmodule

// File: tb/tb_edge_event_recorder.sv
// Directed bench for edge_event_recorder: a 12-bit and a 4-bit timestamp instance share
// stimulus; expected event words are queued when a change is driven and compared when
// each instance hands an event to the consumer.
module tb_edge_event_recorder;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       a;
  logic       b;
  logic       rd_ready;
  logic       clr_ovf;

  logic       overflow12;
  logic [7:0] drop12;
  logic [3:0] level12;
  logic       overflow4;
  logic [7:0] drop4;
  logic [3:0] level4;

  int         errors;
  int         checks;
  int         ts_m;

  logic [15:0] exp12_q[$];
  logic [7:0]  exp4_q[$];
  logic [15:0] e12;
  logic [7:0]  e4;

  edge_event_recorder_if #(.TS_W(12)) rd12 ();
  edge_event_recorder_if #(.TS_W(4))  rd4 ();

  assign rd12.rd_ready = rd_ready;
  assign rd4.rd_ready  = rd_ready;

  edge_event_recorder #(
    .DEPTH (8),
    .TS_W  (12)
  ) dut12 (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .a_in       (a),
    .b_in       (b),
    .clr_ovf    (clr_ovf),
    .rd         (rd12),
    .overflow   (overflow12),
    .drop_count (drop12),
    .level      (level12)
  );

  edge_event_recorder #(
    .DEPTH (8),
    .TS_W  (4)
  ) dut4 (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .a_in       (a),
    .b_in       (b),
    .clr_ovf    (clr_ovf),
    .rd         (rd4),
    .overflow   (overflow4),
    .drop_count (drop4),
    .level      (level4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference cycle counter: zero while reset, then one step per rising edge.
  always @(posedge clock) begin
    if (reset) ts_m <= 0;
    else       ts_m <= ts_m + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive new a/b values this cycle; queue the expected word if an event should land.
  task automatic set_ab(input logic na, input logic nb, input bit expect_evt);
    logic ach;
    logic bch;
    ach = na ^ a;
    bch = nb ^ b;
    if (expect_evt) begin
      exp12_q.push_back({na, nb, ach, bch, ts_m[11:0]});
      exp4_q.push_back({na, nb, ach, bch, ts_m[3:0]});
    end
    a = na;
    b = nb;
  endtask

  // Hold reset for n edges; returns inside the PRIME cycle with ts_m == 0.
  task automatic do_reset(input int n, input logic na, input logic nb);
    reset    = 1'b1;
    rd_ready = 1'b0;
    clr_ovf  = 1'b0;
    a        = na;
    b        = nb;
    repeat (n) tick();
    reset = 1'b0;
    exp12_q.delete();
    exp4_q.delete();
  endtask

  // Consumer-side scoreboard: every accepted handshake must match the queue head.
  always @(negedge clock) begin
    if (!reset && rd12.rd_valid && rd_ready) begin
      e12 = 'x;
      if (exp12_q.size() != 0) e12 = exp12_q.pop_front();
      chk("pop12", 32'(rd12.rd_data), 32'(e12));
    end
    if (!reset && rd4.rd_valid && rd_ready) begin
      e4 = 'x;
      if (exp4_q.size() != 0) e4 = exp4_q.pop_front();
      chk("pop4", 32'(rd4.rd_data), 32'(e4));
    end
  end

  initial begin
    errors   = 0;
    checks   = 0;
    reset    = 1'b1;
    enable   = 1'b0;
    a        = 1'b0;
    b        = 1'b0;
    rd_ready = 1'b0;
    clr_ovf  = 1'b0;
    repeat (3) tick();

    chk("rst_valid", 32'(rd12.rd_valid), 32'd0);
    chk("rst_level", 32'(level12), 32'd0);
    chk("rst_ovf", 32'(overflow12), 32'd0);
    chk("rst_drop", 32'(drop12), 32'd0);
    chk("rst_valid4", 32'(rd4.rd_valid), 32'd0);

    // Single b change at timestamp 20; a=1 applied in PRIME must not produce an event.
    enable = 1'b1;
    do_reset(1, 1'b1, 1'b0);
    for (int i = 0; i < 100 && ts_m != 20; i++) tick();
    set_ab(1'b1, 1'b1, 1'b1);
    tick();
    chk("lat21_valid", 32'(rd12.rd_valid), 32'd0);
    tick();
    chk("lat22_valid", 32'(rd12.rd_valid), 32'd1);
    chk("lat22_data", 32'(rd12.rd_data), 32'h0000_D014);
    chk("lat22_level", 32'(level12), 32'd1);
    chk("lat22_data4", 32'(rd4.rd_data), 32'h0000_00D4);
    tick();
    chk("hold_data", 32'(rd12.rd_data), 32'h0000_D014);
    rd_ready = 1'b1;
    tick();
    chk("pop_level", 32'(level12), 32'd0);

    // Joint a/b toggles every 5 cycles drained immediately.
    for (int k = 0; k < 4; k++) begin
      repeat (5) tick();
      set_ab(!a, !b, 1'b1);
    end
    repeat (4) tick();
    chk("joint_level", 32'(level12), 32'd0);
    chk("joint_left", exp12_q.size(), 32'd0);

    // Twelve events with no consumer: eight stored, four dropped.
    rd_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      set_ab(!a, b, k < 8);
      repeat (2) tick();
    end
    chk("full_level", 32'(level12), 32'd8);
    chk("full_ovf", 32'(overflow12), 32'd1);
    chk("full_drop", 32'(drop12), 32'd4);
    chk("full_drop4", 32'(drop4), 32'd4);

    // Full queue, pop coincides with the push of a new event: nothing dropped.
    set_ab(!a, b, 1'b1);
    tick();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("popush_level", 32'(level12), 32'd8);
    chk("popush_drop", 32'(drop12), 32'd4);

    // Clear coincident with a drop wins; a later drop counts from zero.
    set_ab(!a, b, 1'b0);
    tick();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("clrwin_ovf", 32'(overflow12), 32'd0);
    chk("clrwin_drop", 32'(drop12), 32'd0);
    set_ab(!a, b, 1'b0);
    repeat (2) tick();
    chk("redrop_ovf", 32'(overflow12), 32'd1);
    chk("redrop_drop", 32'(drop12), 32'd1);

    // Drop counter saturation.
    for (int k = 0; k < 260; k++) begin
      set_ab(!a, b, 1'b0);
      tick();
    end
    repeat (2) tick();
    chk("sat_drop", 32'(drop12), 32'd255);
    chk("sat_drop4", 32'(drop4), 32'd255);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("clr_drop", 32'(drop12), 32'd0);
    chk("clr_ovf", 32'(overflow12), 32'd0);

    // Drain in order, then hold rd_ready on an empty queue.
    rd_ready = 1'b1;
    for (int i = 0; i < 30 && level12 != 0; i++) tick();
    repeat (3) tick();
    chk("drain_level", 32'(level12), 32'd0);
    chk("drain_valid", 32'(rd12.rd_valid), 32'd0);
    chk("drain_left", exp12_q.size(), 32'd0);

    // Disabled toggles are ignored; event at cycle 17 wraps the 4-bit timestamp to 1.
    enable = 1'b0;
    do_reset(2, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      repeat (3) tick();
      set_ab(!a, b, 1'b0);
    end
    for (int i = 0; i < 40 && ts_m != 16; i++) tick();
    chk("dis_level", 32'(level12), 32'd0);
    chk("dis_level4", 32'(level4), 32'd0);
    tick();
    enable = 1'b1;
    set_ab(!a, b, 1'b1);
    repeat (2) tick();
    chk("wrap_valid4", 32'(rd4.rd_valid), 32'd1);
    chk("wrap_data4", 32'(rd4.rd_data), 32'h0000_00A1);
    chk("wrap_data12", 32'(rd12.rd_data), 32'h0000_A011);
    set_ab(a, !b, 1'b1);
    tick();
    enable = 1'b0;
    repeat (3) tick();
    chk("keep_level", 32'(level12), 32'd2);
    rd_ready = 1'b1;
    repeat (4) tick();
    chk("keep_drain", 32'(level12), 32'd0);
    chk("keep_left4", exp4_q.size(), 32'd0);

    // Reset with three pending events, then PRIME suppresses the first change.
    enable   = 1'b1;
    rd_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_ab(!a, b, 1'b1);
      repeat (2) tick();
    end
    tick();
    chk("pend_level", 32'(level12), 32'd3);
    reset    = 1'b1;
    rd_ready = 1'b1;
    tick();
    reset    = 1'b0;
    rd_ready = 1'b0;
    exp12_q.delete();
    exp4_q.delete();
    chk("mid_rst_valid", 32'(rd12.rd_valid), 32'd0);
    chk("mid_rst_level", 32'(level12), 32'd0);
    chk("mid_rst_level4", 32'(level4), 32'd0);
    set_ab(!a, b, 1'b0);
    repeat (4) tick();
    chk("prime_level", 32'(level12), 32'd0);
    set_ab(a, !b, 1'b1);
    repeat (2) tick();
    chk("post_valid", 32'(rd12.rd_valid), 32'd1);
    rd_ready = 1'b1;
    repeat (3) tick();
    chk("post_level", 32'(level12), 32'd0);
    chk("post_left", exp12_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/edge_event_recorder.md
EDGE_EVENT_RECORDER -- requirements
Module: edge_event_recorder

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; power of two, 2..64.
REQ-002 Parameter TS_W, default 12, timestamp width in bits.
REQ-003 clock  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  high = capture events; low = no capture, timestamp keeps running.
REQ-006 a_in  input  1  observed signal a, synchronous to clock.
REQ-007 b_in  input  1  observed signal b, synchronous to clock.
REQ-008 rd_ready  input  1  consumer accepts the head event.
REQ-009 clr_ovf  input  1  one-cycle pulse; clears overflow and drop_count.
REQ-010 rd_valid  output  1  head event available.
REQ-011 rd_data  output  TS_W+4  head event word {a_now, b_now, a_chg, b_chg, timestamp}.
REQ-012 overflow  output  1  sticky: at least one event dropped.
REQ-013 drop_count  output  8  dropped events, saturating at 255.
REQ-014 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-015 Sample registers a_q/b_q hold the previous-cycle values of a_in/b_in.
REQ-016 Event condition: enable high and (a_in != a_q or b_in != b_q), excluding the prime cycle.
REQ-017 Event word: a_now=a_in, b_now=b_in, a_chg=(a_in^a_q), b_chg=(b_in^b_q), timestamp = counter value in the detection cycle.
REQ-018 Simultaneous a and b change produces one event with both chg bits set, never two events.
REQ-019 Timestamp counter increments every cycle, wraps from 2^TS_W-1 to 0, and is unaffected by enable.
REQ-020 State machine PRIME -> RUN: PRIME lasts exactly the first cycle after reset release, loads a_q/b_q and generates no event.
REQ-021 An event is pushed in the cycle after detection; rd_valid rises in the cycle after the push (2-cycle detection-to-valid latency from an empty FIFO).
REQ-022 Handshake: pop occurs when rd_valid and rd_ready are both high; rd_data is stable while rd_valid is high and rd_ready is low.
REQ-023 FIFO order is strict first-in first-out; pointers wrap modulo DEPTH.
REQ-024 Full with no pop: the event is dropped, overflow is set, and drop_count increments (saturating at 255).
REQ-025 Full with a pop in the same cycle: the push is accepted, nothing is dropped, and level is unchanged.
REQ-026 Empty with rd_ready high: no pop and no pointer change.
REQ-027 clr_ovf coincident with a drop: the clear wins, leaving overflow=0 and drop_count=0.
REQ-028 Deasserting enable does not flush stored events; the consumer may keep draining.

Reset
REQ-029 While reset is high: FIFO emptied, rd_valid=0, level=0, overflow=0, drop_count=0, timestamp=0, state=PRIME.
REQ-030 rd_data is don't-care while rd_valid=0.
REQ-031 Reset asserted mid-operation discards pending events at the next rising edge, with no partial pop.

Structure
REQ-032 Shared package edge_event_pkg holds field offsets (A_NOW, B_NOW, A_CHG, B_CHG, TS_LSB), the DROP_W=8 constant and the PRIME/RUN state encoding.
REQ-033 One sub-module, event_fifo: a synchronous FIFO with push/pop/full/empty/level, parameterized by width and depth.
REQ-034 Detection, timestamp and overflow logic stay in the top module.

Verification
REQ-035 Scenario: reset, a=1, b=0 held, then at timestamp 20 drive b=1 -> one event {1,1,0,1,ts=20} with rd_valid at ts=22.
REQ-036 Scenario: toggle a and b together every 5 cycles, rd_ready=1 -> each event has a_chg=b_chg=1 and successive timestamps differ by 5.
REQ-037 Scenario: rd_ready=0, DEPTH=8, 12 events -> level=8, overflow=1, drop_count=4; draining then returns the first 8 in order.
REQ-038 Scenario: FIFO full, rd_ready=1 and a new event in the same cycle -> no drop and level stays 8.
REQ-039 Scenario: TS_W=4, event at cycle 17 -> timestamp=1 (wrap); enable=0 during toggles -> no events pushed.
REQ-040 Scenario: reset pulse with 3 pending events -> rd_valid=0 next cycle, and the first post-reset change is reported only after the PRIME cycle.
